// File: rtl/bitserial_alu_seq.sv
// Bit-serial sequencer: feeds a 1-bit ALU slice LSB first, holds the inter-bit
// carry, and reassembles the W-bit result behind valid/ready handshakes.
module bitserial_alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [2:0]   in_op,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_cout,
  output logic         out_err,
  output logic         slice_a,
  output logic         slice_b,
  output logic [2:0]   slice_op,
  output logic         slice_cin,
  input  logic         slice_out,
  input  logic         slice_cout,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [2:0] OP_ADD = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_sr_q, b_sr_q, res_q;
  logic [2:0]    op_q;
  logic [CW-1:0] cnt_q;
  logic          carry_q;
  logic          err_q;

  logic          reserved_s;
  logic          last_s;
  logic [W-1:0]  res_shift_s;

  // Opcodes 110 and 111 are reserved and bypass the shift phase entirely.
  assign reserved_s = in_op[2] & in_op[1];
  assign last_s     = (cnt_q == CW'(W - 1));

  generate
    if (W == 1) begin : g_res_w1
      assign res_shift_s = slice_out;
    end else begin : g_res_wn
      assign res_shift_s = {slice_out, res_q[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) state_d = reserved_s ? S_DONE : S_SHIFT;
        else          state_d = S_IDLE;
      end
      S_SHIFT: begin
        if (last_s) state_d = S_DONE;
        else        state_d = S_SHIFT;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
        else           state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      op_q    <= 3'b000;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_sr_q  <= in_a;
            b_sr_q  <= in_b;
            op_q    <= in_op;
            cnt_q   <= '0;
            carry_q <= (in_op == OP_ADD) ? in_cin : 1'b0;
            if (reserved_s) begin
              res_q <= '0;
              err_q <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          res_q   <= res_shift_s;
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          // Only ADD propagates carry; other ops may return junk on slice_cout.
          carry_q <= (op_q == OP_ADD) ? slice_cout : 1'b0;
        end
        S_DONE: begin
          if (out_ready) err_q <= 1'b0;
        end
        default: begin
          err_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    slice_a    = 1'b0;
    slice_b    = 1'b0;
    slice_op   = 3'b000;
    slice_cin  = 1'b0;
    out_result = res_q;
    out_cout   = carry_q;
    out_err    = err_q;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_SHIFT: begin
        busy      = 1'b1;
        slice_a   = a_sr_q[0];
        slice_b   = b_sr_q[0];
        slice_op  = op_q;
        slice_cin = carry_q;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bitserial_alu_seq.sv
// Directed bench for bitserial_alu_seq with a behavioural 1-bit slice attached.
module tb_bitserial_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic       in_cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_cout;
  logic       out_err;
  logic       slice_a, slice_b, slice_cin;
  logic [2:0] slice_op;
  logic       slice_out, slice_cout;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bitserial_alu_seq #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout), .out_err(out_err),
    .slice_a(slice_a), .slice_b(slice_b), .slice_op(slice_op), .slice_cin(slice_cin),
    .slice_out(slice_out), .slice_cout(slice_cout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice model; non-ADD ops return cout=a so the sequencer must ignore it.
  always_comb begin
    slice_out  = 1'b0;
    slice_cout = slice_a;
    case (slice_op)
      3'b000: slice_out = slice_a & slice_b;
      3'b001: slice_out = slice_a | slice_b;
      3'b010: slice_out = slice_a ^ slice_b;
      3'b011: slice_out = ~slice_a;
      3'b100: begin
        slice_out  = slice_a ^ slice_b ^ slice_cin;
        slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
      end
      3'b101: slice_out = slice_a;
      default: begin
        slice_out  = 1'b0;
        slice_cout = 1'b0;
      end
    endcase
  end

  // Offers one request from IDLE and returns cycles from accept to out_valid (-1 on timeout).
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic cin, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_cin = cin;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
    in_op = 3'b000; in_cin = 1'b0; out_ready = 1'b0;
    #12;
    checks++;
    if ({out_valid, out_result, out_cout, out_err, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got v=%b r=%h c=%b e=%b busy=%b required all 0",
               out_valid, out_result, out_cout, out_err, busy);
    end
    checks++;
    if ({slice_a, slice_b, slice_op, slice_cin} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_slice got %b required 000000", {slice_a, slice_b, slice_op, slice_cin});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_and();
    int lat;
    issue(8'hA5, 8'h3C, 3'b000, 1'b0, lat);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL and_latency got %0d required 9", lat); end
    checks++;
    if ({out_result, out_cout, out_err} !== {8'h24, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL and_result got r=%h c=%b e=%b required 24 0 0", out_result, out_cout, out_err);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL and_done_flags got in_ready=%b busy=%b required 0 1", in_ready, busy);
    end
    release_result();
  endtask

  task automatic test_add();
    int lat;
    issue(8'hFF, 8'h01, 3'b100, 1'b0, lat);
    checks++;
    if (lat !== 9 || out_result !== 8'h00 || out_cout !== 1'b1) begin
      errors++;
      $display("FAIL add_ff_01 got lat=%0d r=%h c=%b required 9 00 1", lat, out_result, out_cout);
    end
    release_result();
    issue(8'h12, 8'h34, 3'b100, 1'b1, lat);
    checks++;
    if (lat !== 9 || out_result !== 8'h47 || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL add_12_34_c1 got lat=%0d r=%h c=%b required 9 47 0", lat, out_result, out_cout);
    end
    release_result();
  endtask

  task automatic test_slice_drive();
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_op = 3'b100; in_cin = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if ({slice_a, slice_b, slice_op, slice_cin, busy, in_ready} !== 8'b00_100_1_1_0) begin
      errors++;
      $display("FAIL slice_bit0 got a=%b b=%b op=%b cin=%b busy=%b rdy=%b required 0 0 100 1 1 0",
               slice_a, slice_b, slice_op, slice_cin, busy, in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({slice_a, slice_b, slice_cin} !== 3'b100) begin
      errors++;
      $display("FAIL slice_bit1 got a=%b b=%b cin=%b required 1 0 0", slice_a, slice_b, slice_cin);
    end
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    release_result();
  endtask

  task automatic test_not_pass();
    int lat;
    issue(8'h0F, 8'hFF, 3'b011, 1'b1, lat);
    checks++;
    if (lat !== 9 || out_result !== 8'hF0 || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL not_0f got lat=%0d r=%h c=%b required 9 f0 0", lat, out_result, out_cout);
    end
    release_result();
    issue(8'h5A, 8'h00, 3'b101, 1'b1, lat);
    checks++;
    if (lat !== 9 || out_result !== 8'h5A || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL pass_5a got lat=%0d r=%h c=%b required 9 5a 0", lat, out_result, out_cout);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(8'h81, 8'h18, 3'b001, 1'b0, lat);
    checks++;
    if (lat !== 9 || out_result !== 8'h99) begin
      errors++;
      $display("FAIL bp_or got lat=%0d r=%h required 9 99", lat, out_result);
    end
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h0F; in_op = 3'b000; in_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 8'h99 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d got v=%b r=%h rdy=%b required 1 99 0", i, out_valid, out_result, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle got v=%b rdy=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 9 || out_valid !== 1'b1 || out_result !== 8'h0F) begin
      errors++;
      $display("FAIL bp_next got lat=%0d v=%b r=%h required 9 1 0f", lat, out_valid, out_result);
    end
    release_result();
  endtask

  task automatic test_reserved();
    int lat;
    issue(8'hFF, 8'hFF, 3'b110, 1'b1, lat);
    checks++;
    if (lat !== 1 || out_result !== 8'h00 || out_err !== 1'b1 || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_110 got lat=%0d r=%h e=%b c=%b required 1 00 1 0", lat, out_result, out_err, out_cout);
    end
    checks++;
    if ({slice_a, slice_b, slice_op, slice_cin} !== 6'b000000) begin
      errors++;
      $display("FAIL rsvd_slice got %b required 000000", {slice_a, slice_b, slice_op, slice_cin});
    end
    release_result();
    checks++;
    if (out_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsvd_clear got e=%b rdy=%b required 0 1", out_err, in_ready);
    end
    issue(8'h3C, 8'hC3, 3'b111, 1'b0, lat);
    checks++;
    if (lat !== 1 || out_err !== 1'b1 || out_result !== 8'h00) begin
      errors++;
      $display("FAIL rsvd_111 got lat=%0d e=%b r=%h required 1 1 00", lat, out_err, out_result);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_op = 3'b100; in_cin = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_result, out_cout, out_err, busy} !== 12'h000 ||
        {slice_a, slice_b, slice_op, slice_cin} !== 6'b000000) begin
      errors++;
      $display("FAIL midreset_outputs got v=%b r=%h c=%b e=%b busy=%b slice=%b required all 0",
               out_valid, out_result, out_cout, out_err, busy, {slice_a, slice_b, slice_op, slice_cin});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release got rdy=%b v=%b required 1 0", in_ready, out_valid);
    end
    issue(8'hF0, 8'hFF, 3'b010, 1'b0, lat);
    checks++;
    if (lat !== 9 || out_result !== 8'h0F || out_cout !== 1'b0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_xor got lat=%0d r=%h c=%b e=%b required 9 0f 0 0",
               lat, out_result, out_cout, out_err);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_and();
    test_add();
    test_slice_drive();
    test_not_pass();
    test_backpressure();
    test_reserved();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
